data_serializer: RTL and testbench
==================================

Name: data_serializer

Overview:
- Parametrised successor to the fixed 2:1 packer.
- Splits one IW-bit sample into NSLICE = ceil(IW/OW) output words, MSB slice first, for the USB FIFO path.
- Adds valid/ready handshakes on both sides, a last-slice marker and zero-padding for non-integer ratios.
- Sits between the processing chain output and the USB FIFO write interface.

Parameters:
- IW, 24, input sample width in bits (>= 1).
- OW, 8, output word width in bits (USB data width, >= 1).
- HEADER, 8'hA5 (OW bits), marker word emitted before each sample; used only when the optional feature is compiled in.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- data_i  in  IW  input sample.
- valid_i  in  1  data_i valid.
- ready_o  out  1  block can accept a sample this cycle.
- data_o  out  OW  output word (registered).
- valid_o  out  1  data_o valid (registered).
- ready_i  in  1  downstream accepts data_o this cycle.
- last_o  out  1  data_o is the final slice of the current sample (registered).

Behaviour:
- Derived values:
  - NSLICE = ceil(IW/OW).
  - PADW = NSLICE*OW - IW.
  - The internal holding register is NSLICE*OW bits, loaded with the sample zero-extended at the top by PADW bits.
  - The slice index counter is clog2(NSLICE) bits, minimum 1.
- Reset (rst_n_i low, asynchronous):
  - valid_o=0, last_o=0, data_o=0.
  - Slice index=0, holding register=0, state=IDLE.
  - All of this is immediate and independent of clk_i.
  - A sample partially sent when reset asserts is discarded, with no resume. The first cycle after deassertion is IDLE.
- Handshake rules:
  - Input transfer when valid_i && ready_o.
  - Output transfer when valid_o && ready_i.
  - data_o, last_o and valid_o are held stable while valid_o && !ready_i.
- ready_o (combinational) = (state==IDLE) || (state==SEND && ready_i && last_o).
- States:
  - IDLE: valid_o=0.
    - On input transfer: load the holding register, set data_o to the top slice, valid_o=1, slice index=0, last_o=(NSLICE==1), go to SEND.
    - Latency: data_o is valid exactly 1 cycle after the input transfer.
  - SEND, output transfer on a non-final slice:
    - Index increments.
    - data_o takes the next lower slice.
    - last_o=1 when the new index == NSLICE-1.
  - SEND, output transfer on the final slice:
    - If valid_i is also high, that sample is accepted in the same cycle. The next cycle presents its top slice, with no bubble and state unchanged.
    - Otherwise valid_o=0, last_o=0, go to IDLE.
  - SEND, no output transfer: hold everything. ready_o=0, so valid_i is ignored.
- Throughput: one output word per cycle while ready_i=1. Sustained input rate is 1 sample per NSLICE cycles.
- Slice order: slice k (k=0 first) = holding[(NSLICE-k)*OW-1 : (NSLICE-k-1)*OW]. The padding bits occupy the MSBs of slice 0.
- Degenerate case IW <= OW: NSLICE=1; every word has last_o=1; behaves as a one-entry registered pipeline stage.
- data_i is sampled only on an input transfer. Changes at other times have no effect.

Optional Feature:
- Macro: DATA_SERIALIZER_HEADER_EN.
- Defined:
  - An extra state HDR precedes SEND.
  - On input transfer the first emitted word is HEADER with last_o=0, and the slices follow.
  - Each sample produces NSLICE+1 words; last_o stays on the final data slice.
  - The back-to-back accept on the final slice goes to HDR, not SEND.
  - ready_o is unchanged: IDLE, or final-slice transfer.
- Not defined:
  - HDR state and HEADER are unused and no logic is generated.
  - Behaviour is exactly as above.

Test Plan:
1. Reset/idle: hold rst_n_i=0, then release with valid_i=0 -> valid_o=0, last_o=0, data_o=0, ready_o=1. Assert rst_n_i=0 mid-clock -> outputs clear before the next edge.
2. Basic split (IW=24, OW=8, ready_i=1): data_i=24'h123456 with a valid pulse -> data_o 8'h12, 8'h34, 8'h56 on the 3 following cycles, last_o only with 8'h56.
3. Back-to-back: valid_i held high with samples 24'hAABBCC then 24'h010203, ready_i=1 -> 6 consecutive valid words AA BB CC 01 02 03, no gap; ready_o high only on the cycles CC and 03 are accepted.
4. Backpressure: ready_i=0 for 4 cycles while 8'h34 is presented -> data_o=8'h34 and valid_o=1 held throughout, ready_o=0. After release the sequence continues with 8'h56.
5. Padding (IW=12, OW=8): data_i=12'hABC -> data_o 8'h0A then 8'hBC, last_o on 8'hBC.
6. Header (macro defined, HEADER=8'hA5): data_i=24'h123456 -> A5 12 34 56 with last_o only on 56. Back-to-back second sample starts with A5.

Source files
------------

// File: rtl/data_serializer.sv
// data_serializer: splits one IW-bit sample into NSLICE = ceil(IW/OW) words,
// most significant slice first. Both sides use valid/ready handshakes:
// a transfer happens on a rising clock edge where valid and ready are both high,
// and a presented word (data_o/last_o/valid_o) is held until it is taken.
// Non-integer ratios are zero-padded at the top of the first slice.
// Optional feature macro: DATA_SERIALIZER_HEADER_EN (emit HEADER before each sample).
module data_serializer #(
    parameter int              IW     = 24,
    parameter int              OW     = 8,
    parameter logic [OW-1:0]   HEADER = OW'(8'hA5)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [IW-1:0] data_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic [OW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          last_o
);

    // Holding register is NSLICE*OW bits; the NSLICE*OW-IW pad bits sit above the sample.
    localparam int                NSLICE        = (IW + OW - 1) / OW;
    localparam int                HW            = NSLICE * OW;
    localparam int                IDXW          = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0]   LAST_IDX      = IDXW'(NSLICE - 1);
    localparam logic              FIRST_IS_LAST = (NSLICE == 1);

`ifdef DATA_SERIALIZER_HEADER_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HDR  = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // HEADER only matters when the header feature is compiled in.
    logic unused_header;
    assign unused_header = ^HEADER;
`endif

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [IDXW-1:0] idx_q, idx_d, idx_nx;
    logic [OW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            out_xfer;
    logic            load;

    // Slice k counted from the top: h[(NSLICE-k)*OW-1 -: OW].
    function automatic logic [OW-1:0] slice_of(input logic [HW-1:0] h, input logic [IDXW-1:0] k);
        logic [HW-1:0] t;
        t = h >> ((NSLICE - 1 - int'(k)) * OW);
        return t[OW-1:0];
    endfunction

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign idx_nx  = idx_q + 1'b1;

    // Next-state, next-output and input-ready decode.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        load     = 1'b0;
        out_xfer = valid_q && ready_i;
        // A new sample is taken when idle, or in the same cycle the final slice leaves.
        ready_o  = (state_q == IDLE) || ((state_q == SEND) && ready_i && last_q);

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    load = 1'b1;
                end
            end
            SEND: begin
                if (out_xfer) begin
                    if (last_q) begin
                        if (valid_i) begin
                            load = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d  = idx_nx;
                        data_d = slice_of(hold_q, idx_nx);
                        last_d = (idx_nx == LAST_IDX);
                    end
                end
            end
`ifdef DATA_SERIALIZER_HEADER_EN
            HDR: begin
                if (out_xfer) begin
                    data_d  = slice_of(hold_q, '0);
                    last_d  = FIRST_IS_LAST;
                    state_d = SEND;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accepting a sample always restarts the word sequence from the top.
        if (load) begin
            hold_d  = HW'(data_i);
            idx_d   = '0;
            valid_d = 1'b1;
`ifdef DATA_SERIALIZER_HEADER_EN
            data_d  = HEADER;
            last_d  = 1'b0;
            state_d = HDR;
`else
            data_d  = slice_of(HW'(data_i), '0);
            last_d  = FIRST_IS_LAST;
            state_d = SEND;
`endif
        end
    end

    // State and output registers; reset discards any partially sent sample.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_data_serializer.sv
// Testbench for data_serializer: a 24->8 instance (a) and a padded 12->8 instance (b).
// Expected words ({last, data}) are queued when a sample is issued; monitors pop
// and compare on every output transfer. Honours DATA_SERIALIZER_HEADER_EN.
module tb_data_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [23:0] a_data_i;
    logic        a_valid_i, a_ready_o, a_valid_o, a_ready_i, a_last_o;
    logic [7:0]  a_data_o;
    logic [11:0] b_data_i;
    logic        b_valid_i, b_ready_o, b_valid_o, b_ready_i, b_last_o;
    logic [7:0]  b_data_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_a_q[$];
    logic [8:0] exp_b_q[$];

`ifdef DATA_SERIALIZER_HEADER_EN
    localparam logic [7:0] FIRST_A = 8'hA5;
    localparam logic [7:0] FIRST_B = 8'hA5;
`else
    localparam logic [7:0] FIRST_A = 8'h12;
    localparam logic [7:0] FIRST_B = 8'h0A;
`endif

    data_serializer #(.IW(24), .OW(8), .HEADER(8'hA5)) u_a (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .data_i  (a_data_i),
        .valid_i (a_valid_i),
        .ready_o (a_ready_o),
        .data_o  (a_data_o),
        .valid_o (a_valid_o),
        .ready_i (a_ready_i),
        .last_o  (a_last_o)
    );

    data_serializer #(.IW(12), .OW(8), .HEADER(8'hA5)) u_b (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .data_i  (b_data_i),
        .valid_i (b_valid_i),
        .ready_o (b_ready_o),
        .data_o  (b_data_o),
        .valid_o (b_valid_o),
        .ready_i (b_ready_i),
        .last_o  (b_last_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_header(input bit to_a);
`ifdef DATA_SERIALIZER_HEADER_EN
        if (to_a) exp_a_q.push_back({1'b0, 8'hA5});
        else      exp_b_q.push_back({1'b0, 8'hA5});
`else
        if (to_a) exp_a_q.push_back(9'h000);
        if (to_a) void'(exp_a_q.pop_back());
`endif
    endtask

    // Issue one sample on a; called at posedge+1, returns at posedge+1 after acceptance.
    task automatic send_a(input logic [23:0] d, input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        bit got;
        push_header(1'b1);
        exp_a_q.push_back({1'b0, w0});
        exp_a_q.push_back({1'b0, w1});
        exp_a_q.push_back({1'b1, w2});
        a_data_i  = d;
        a_valid_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (a_ready_o) got = 1'b1;
            @(posedge clk);
            #1;
        end
        a_valid_i = 1'b0;
        check("a_accepted", 32'(got), 32'd1);
    endtask

    task automatic send_b(input logic [11:0] d, input logic [7:0] w0, input logic [7:0] w1);
        bit got;
        push_header(1'b0);
        exp_b_q.push_back({1'b0, w0});
        exp_b_q.push_back({1'b1, w1});
        b_data_i  = d;
        b_valid_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (b_ready_o) got = 1'b1;
            @(posedge clk);
            #1;
        end
        b_valid_i = 1'b0;
        check("b_accepted", 32'(got), 32'd1);
    endtask

    task automatic wait_drain(input bit on_a);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (on_a && exp_a_q.size() == 0 && !a_valid_o) break;
            if (!on_a && exp_b_q.size() == 0 && !b_valid_o) break;
        end
        if (on_a) check("a_drained", 32'(exp_a_q.size()), 32'd0);
        else      check("b_drained", 32'(exp_b_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: compare every word that actually transfers.
    always @(negedge clk) begin
        if (rst_n && a_valid_o && a_ready_i) begin
            if (exp_a_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_word: got %0h, expected no word", a_data_o);
            end else begin
                check("a_word", 32'({a_last_o, a_data_o}), 32'(exp_a_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_valid_o && b_ready_i) begin
            if (exp_b_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_word: got %0h, expected no word", b_data_o);
            end else begin
                check("b_word", 32'({b_last_o, b_data_o}), 32'(exp_b_q.pop_front()));
            end
        end
    end

    // Watchdog bounds the whole run.
    initial begin
        repeat (20000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [8:0] seq[$];
        bit dropped;
        bit found;

        rst_n     = 1'b0;
        a_data_i  = '0;
        a_valid_i = 1'b0;
        a_ready_i = 1'b1;
        b_data_i  = '0;
        b_valid_i = 1'b0;
        b_ready_i = 1'b1;

        // Reset and idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(a_valid_o), 32'd0);
        check("rst_last",  32'(a_last_o),  32'd0);
        check("rst_data",  32'(a_data_o),  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_valid", 32'(a_valid_o), 32'd0);
        check("idle_last",  32'(a_last_o),  32'd0);
        check("idle_data",  32'(a_data_o),  32'd0);
        check("idle_ready", 32'(a_ready_o), 32'd1);
        check("idle_b_valid", 32'(b_valid_o), 32'd0);

        // Mid-clock reset while a sample is stalled: outputs clear before the next edge.
        @(posedge clk);
        #1 a_ready_i = 1'b0;
        send_a(24'h123456, 8'h12, 8'h34, 8'h56);
        @(negedge clk);
        check("inflight_valid", 32'(a_valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(a_valid_o), 32'd0);
        check("async_rst_data",  32'(a_data_o),  32'd0);
        check("async_rst_last",  32'(a_last_o),  32'd0);
        check("async_rst_ready", 32'(a_ready_o), 32'd1);
        exp_a_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        a_ready_i = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(a_valid_o), 32'd0);

        // Basic split with one-cycle latency.
        @(posedge clk);
        #1;
        send_a(24'h123456, 8'h12, 8'h34, 8'h56);
        @(negedge clk);
        check("t2_latency_valid", 32'(a_valid_o), 32'd1);
        check("t2_first_word",    32'(a_data_o),  32'(FIRST_A));
        wait_drain(1'b1);

        // Back-to-back samples with no gap; ready_o only while the final slice leaves.
`ifdef DATA_SERIALIZER_HEADER_EN
        seq = '{9'h0A5, 9'h0AA, 9'h0BB, 9'h1CC, 9'h0A5, 9'h001, 9'h002, 9'h103};
`else
        seq = '{9'h0AA, 9'h0BB, 9'h1CC, 9'h001, 9'h002, 9'h103};
`endif
        foreach (seq[i]) exp_a_q.push_back(seq[i]);
        a_ready_i = 1'b1;
        a_data_i  = 24'hAABBCC;
        a_valid_i = 1'b1;
        @(negedge clk);
        check("t3_idle_ready", 32'(a_ready_o), 32'd1);
        @(posedge clk);
        #1 a_data_i = 24'h010203;
        dropped = 1'b0;
        foreach (seq[k]) begin
            @(negedge clk);
            check("t3_valid", 32'(a_valid_o), 32'd1);
            check("t3_data",  32'(a_data_o),  32'(seq[k][7:0]));
            check("t3_ready", 32'(a_ready_o), 32'(seq[k][8]));
            @(posedge clk);
            #1;
            if (seq[k][8] && !dropped) begin
                a_valid_i = 1'b0;
                dropped   = 1'b1;
            end
        end
        @(negedge clk);
        check("t3_idle_after", 32'(a_valid_o), 32'd0);
        check("t3_queue_empty", 32'(exp_a_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Backpressure while 8'h34 is presented; data_i changes must not matter.
        send_a(24'h123456, 8'h12, 8'h34, 8'h56);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (a_valid_o && a_data_o == 8'h34) begin
                a_ready_i = 1'b0;
                found     = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("t4_found_34", 32'(found), 32'd1);
        a_data_i = 24'hFFFFFF;
        repeat (4) begin
            @(negedge clk);
            check("t4_hold_data",  32'(a_data_o),  32'h34);
            check("t4_hold_valid", 32'(a_valid_o), 32'd1);
            check("t4_hold_last",  32'(a_last_o),  32'd0);
            check("t4_hold_ready", 32'(a_ready_o), 32'd0);
        end
        @(posedge clk);
        #1 a_ready_i = 1'b1;
        wait_drain(1'b1);

        // Padding on the 12->8 instance.
        send_b(12'hABC, 8'h0A, 8'hBC);
        @(negedge clk);
        check("t5_latency_valid", 32'(b_valid_o), 32'd1);
        check("t5_first_word",    32'(b_data_o),  32'(FIRST_B));
        wait_drain(1'b0);
        send_b(12'h5F0, 8'h05, 8'hF0);
        wait_drain(1'b0);

        check("final_a_queue", 32'(exp_a_q.size()), 32'd0);
        check("final_b_queue", 32'(exp_b_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
